// File: rtl/skl_32_seq_sub_8_pkg.sv
// Shared constants, FSM state type and the Sklansky prefix-level helper
// for the sequential 32-bit subtractor.
package skl_32_seq_sub_8_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned SLICE_W    = 8;
    localparam int unsigned NUM_SLICES = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // One Sklansky level: every bit whose lvl-th index bit is set combines
    // with the top bit of the preceding aligned group. Returns {g, p}.
    function automatic logic [15:0] prefix_level(input logic [7:0] g,
                                                 input logic [7:0] p,
                                                 input int unsigned lvl);
        logic [7:0]  go;
        logic [7:0]  po;
        int unsigned j;
        logic [2:0]  ii;
        logic [2:0]  jj;
        go = g;
        po = p;
        for (int unsigned i = 0; i < SLICE_W; i++) begin
            if (((i >> lvl) & 32'd1) == 32'd1) begin
                j      = ((i >> lvl) << lvl) - 32'd1;
                ii     = i[2:0];
                jj     = j[2:0];
                go[ii] = g[ii] | (p[ii] & g[jj]);
                po[ii] = p[ii] & p[jj];
            end
        end
        return {go, po};
    endfunction

endpackage

// File: rtl/skl_32_seq_sub_8_skl8.sv
// 8-bit Sklansky parallel-prefix adder slice: s = a + b + cin.
module skl8
    import skl_32_seq_sub_8_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    logic [7:0] g0, p0;
    logic [7:0] g1, p1;
    logic [7:0] g2, p2;
    logic [7:0] g3, p3;
    logic [8:0] c;

    always_comb begin
        g0       = a & b;
        p0       = a ^ b;
        {g1, p1} = prefix_level(g0, p0, 0);
        {g2, p2} = prefix_level(g1, p1, 1);
        {g3, p3} = prefix_level(g2, p2, 2);
        // Group generate/propagate over [i:0] fold in cin to give carry into bit i+1.
        c        = {g3 | (p3 & {8{cin}}), cin};
        s        = p0 ^ c[7:0];
        cout     = c[8];
    end

endmodule

// File: rtl/skl_32_seq_sub_8.sv
// Multi-cycle 32-bit subtractor d = x1 - x2 - bin, one shared skl8 slice
// stepped LSB-first over four cycles behind valid/ready handshakes.
module skl_32_seq_sub_8
    import skl_32_seq_sub_8_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] d,
    output logic        bout
);

    state_t      state, state_nx;
    logic [1:0]  step;
    logic        carry;
    logic [31:0] x1r, x2r;
    logic        binr;

    logic [7:0]  a_sl, b_sl, s_sl;
    logic        c_sl, cout_sl;

    // Byte select by step; subtrahend inverted for two's complement.
    always_comb begin
        a_sl = x1r[7:0];
        b_sl = ~x2r[7:0];
        case (step)
            2'd0: begin a_sl = x1r[7:0];   b_sl = ~x2r[7:0];   end
            2'd1: begin a_sl = x1r[15:8];  b_sl = ~x2r[15:8];  end
            2'd2: begin a_sl = x1r[23:16]; b_sl = ~x2r[23:16]; end
            2'd3: begin a_sl = x1r[31:24]; b_sl = ~x2r[31:24]; end
            default: ;
        endcase
        c_sl = (step == 2'd0) ? ~binr : carry;
    end

    skl8 u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (c_sl),
        .s    (s_sl),
        .cout (cout_sl)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = BUSY;
            end
            BUSY: begin
                if (step == 2'd3) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step  <= '0;
            carry <= 1'b0;
            x1r   <= '0;
            x2r   <= '0;
            binr  <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x1r  <= x1;
                        x2r  <= x2;
                        binr <= bin;
                        step <= '0;
                    end
                end
                BUSY: begin
                    case (step)
                        2'd0: d[7:0]   <= s_sl;
                        2'd1: d[15:8]  <= s_sl;
                        2'd2: d[23:16] <= s_sl;
                        2'd3: d[31:24] <= s_sl;
                        default: ;
                    endcase
                    carry <= cout_sl;
                    step  <= step + 2'd1;
                    if (step == 2'd3) bout <= ~cout_sl;
                end
                default: ;
            endcase
        end
    end

endmodule
